// File: rtl/vend_fsm_param.sv
// Parameterised vending controller: collects coins, releases one item at PRICE,
// then pays back any surplus credit one UNIT coin per cycle.
module vend_fsm_param #(
   parameter int CW    = 8,
   parameter int PRICE = 15,
   parameter int UNIT  = 5,
   parameter int V0    = 5,
   parameter int V1    = 10,
   parameter int V2    = 20
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          coin_valid,
   input  logic [1:0]    coin_type,
   input  logic          cancel,
   output logic          purchase,
   output logic          change_pulse,
   output logic          coin_reject,
   output logic          busy,
   output logic [CW-1:0] credit,
   output logic [1:0]    state
);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] COLLECT = 2'b01;
   localparam logic [1:0] VEND    = 2'b10;
   localparam logic [1:0] REFUND  = 2'b11;

   localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
   localparam logic [CW-1:0] UNIT_C  = CW'(UNIT);
   localparam logic [CW-1:0] V0_C    = CW'(V0);
   localparam logic [CW-1:0] V1_C    = CW'(V1);
   localparam logic [CW-1:0] V2_C    = CW'(V2);

   // Reject parameter sets that would make the change loop miss zero or overflow.
   if (UNIT <= 0) begin : g_unit_check
      $error("vend_fsm_param: UNIT must be positive");
   end else if (PRICE <= 0 || V0 <= 0 || V1 <= 0 || V2 <= 0 ||
                PRICE % UNIT != 0 || V0 % UNIT != 0 ||
                V1 % UNIT != 0 || V2 % UNIT != 0 ||
                PRICE + V2 - UNIT >= (2 ** CW)) begin : g_value_check
      $error("vend_fsm_param: illegal PRICE/coin values for CW and UNIT");
   end

   logic [CW-1:0] coin_value;
   logic          collecting;
   logic          take_cancel;
   logic          accept;
   logic [CW-1:0] new_credit;
   logic [CW-1:0] remain;

   always_comb begin
      coin_value = V0_C;
      case (coin_type)
         2'd0:    coin_value = V0_C;
         2'd1:    coin_value = V1_C;
         2'd2:    coin_value = V2_C;
         default: coin_value = '0;
      endcase
   end

   assign collecting  = (state == IDLE) || (state == COLLECT);
   assign take_cancel = (state == COLLECT) && cancel;
   assign accept      = collecting && coin_valid && (coin_type != 2'd3) && !take_cancel;
   assign new_credit  = credit + coin_value;
   assign remain      = credit - PRICE_C;

   assign purchase     = (state == VEND);
   assign change_pulse = (state == REFUND);
   assign busy         = (state == VEND) || (state == REFUND);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, matching the hardware.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         coin_reject <= 1'b0;
      end else begin
         coin_reject <= coin_valid && !accept;
         case (state)
            IDLE, COLLECT: begin
               if (take_cancel) begin
                  state <= REFUND;
               end else if (accept) begin
                  credit <= new_credit;
                  state  <= (new_credit >= PRICE_C) ? VEND : COLLECT;
               end
            end
            VEND: begin
               credit <= remain;
               state  <= (remain != '0) ? REFUND : IDLE;
            end
            default: begin
               credit <= credit - UNIT_C;
               if (credit == UNIT_C) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: stimulus queues the expected output
// cycles, a negedge monitor pops and compares whenever the DUT shows activity.
module tb_vend_fsm_param;

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_COLLECT = 2'b01;
   localparam logic [1:0] S_VEND    = 2'b10;
   localparam logic [1:0] S_REFUND  = 2'b11;

   logic       clock = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       cancel;
   logic       purchase;
   logic       change_pulse;
   logic       coin_reject;
   logic       busy;
   logic [7:0] credit;
   logic [1:0] state;

   typedef struct packed {
      logic       p;
      logic       c;
      logic       r;
      logic       b;
      logic [1:0] st;
      logic [7:0] cr;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic run    = 1'b0;

   vend_fsm_param dut (
      .clock        (clock),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .cancel       (cancel),
      .purchase     (purchase),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .busy         (busy),
      .credit       (credit),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One clock with the given inputs, then inputs return to idle.
   task automatic step(input logic cv, input logic [1:0] ct, input logic cc);
      coin_valid = cv;
      coin_type  = ct;
      cancel     = cc;
      @(posedge clock);
      #1;
      coin_valid = 1'b0;
      coin_type  = 2'd0;
      cancel     = 1'b0;
   endtask

   task automatic expect_ev(input logic p, input logic c, input logic r,
                            input logic [1:0] st, input logic [7:0] cr);
      exp_t e;
      e.p  = p;
      e.c  = c;
      e.r  = r;
      e.b  = (st == S_VEND) || (st == S_REFUND);
      e.st = st;
      e.cr = cr;
      exp_q.push_back(e);
   endtask

   task automatic check_rest(input string tag, input logic [1:0] st, input logic [7:0] cr);
      check({tag, "_state"}, int'(state), int'(st));
      check({tag, "_credit"}, int'(credit), int'(cr));
   endtask

   always @(negedge clock) begin
      if (run) begin
         if (purchase || change_pulse || coin_reject) begin
            if (exp_q.size() == 0) begin
               check("spurious_output", int'({purchase, change_pulse, coin_reject}), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("purchase", int'(purchase), int'(e.p));
               check("change_pulse", int'(change_pulse), int'(e.c));
               check("coin_reject", int'(coin_reject), int'(e.r));
               check("busy", int'(busy), int'(e.b));
               check("ev_state", int'(state), int'(e.st));
               check("ev_credit", int'(credit), int'(e.cr));
            end
         end else if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("missed_output", int'({purchase, change_pulse, coin_reject}),
                  int'({e.p, e.c, e.r}));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      coin_valid = 1'b0;
      coin_type  = 2'd0;
      cancel     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_rest("reset", S_IDLE, 8'd0);
      check("reset_reject", int'(coin_reject), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_purchase", int'(purchase), 0);
      run = 1'b1;

      // coin 10 then 5: exact price, no change
      step(1'b1, 2'd1, 1'b0);
      check_rest("c10", S_COLLECT, 8'd10);
      step(1'b1, 2'd0, 1'b0);
      expect_ev(1'b1, 1'b0, 1'b0, S_VEND, 8'd15);
      step(1'b0, 2'd0, 1'b0);
      check_rest("exact_done", S_IDLE, 8'd0);
      step(1'b0, 2'd0, 1'b0);

      // coin 10 then 10: one change coin
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      expect_ev(1'b1, 1'b0, 1'b0, S_VEND, 8'd20);
      step(1'b0, 2'd0, 1'b0);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd5);
      step(1'b0, 2'd0, 1'b0);
      check_rest("c10c10_done", S_IDLE, 8'd0);

      // coin 10 then cancel: two change coins, no purchase
      step(1'b1, 2'd1, 1'b0);
      step(1'b0, 2'd0, 1'b1);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd10);
      step(1'b0, 2'd0, 1'b0);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd5);
      step(1'b0, 2'd0, 1'b0);
      check_rest("cancel_done", S_IDLE, 8'd0);

      // single coin 20 from IDLE
      step(1'b1, 2'd2, 1'b0);
      expect_ev(1'b1, 1'b0, 1'b0, S_VEND, 8'd20);
      step(1'b0, 2'd0, 1'b0);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd5);
      step(1'b0, 2'd0, 1'b0);
      check_rest("c20_done", S_IDLE, 8'd0);

      // three 5s reach price exactly on the boundary
      step(1'b1, 2'd0, 1'b0);
      step(1'b1, 2'd0, 1'b0);
      check_rest("c5c5", S_COLLECT, 8'd10);
      step(1'b1, 2'd0, 1'b0);
      expect_ev(1'b1, 1'b0, 1'b0, S_VEND, 8'd15);
      step(1'b0, 2'd0, 1'b0);
      check_rest("c5x3_done", S_IDLE, 8'd0);

      // invalid coin_type in IDLE
      step(1'b1, 2'd3, 1'b0);
      expect_ev(1'b0, 1'b0, 1'b1, S_IDLE, 8'd0);
      step(1'b0, 2'd0, 1'b0);
      check("reject_one_cycle", int'(coin_reject), 0);

      // coin during REFUND is rejected and does not add credit
      step(1'b1, 2'd1, 1'b0);
      step(1'b0, 2'd0, 1'b1);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd10);
      step(1'b1, 2'd0, 1'b0);
      expect_ev(1'b0, 1'b1, 1'b1, S_REFUND, 8'd5);
      step(1'b0, 2'd0, 1'b0);
      check_rest("refund_coin_done", S_IDLE, 8'd0);
      check("refund_reject_cleared", int'(coin_reject), 0);

      // coin with cancel: cancel wins, coin rejected
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd0, 1'b1);
      expect_ev(1'b0, 1'b1, 1'b1, S_REFUND, 8'd10);
      step(1'b0, 2'd0, 1'b0);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd5);
      step(1'b0, 2'd0, 1'b0);
      check_rest("coin_cancel_done", S_IDLE, 8'd0);

      // reset in REFUND with credit 10 forfeits change
      step(1'b1, 2'd1, 1'b0);
      step(1'b0, 2'd0, 1'b1);
      expect_ev(1'b0, 1'b1, 1'b0, S_REFUND, 8'd10);
      reset = 1'b1;
      step(1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      check_rest("mid_reset", S_IDLE, 8'd0);
      check("mid_reset_change", int'(change_pulse), 0);
      step(1'b0, 2'd0, 1'b0);
      check_rest("post_reset", S_IDLE, 8'd0);

      @(negedge clock);
      run = 1'b0;
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vend_fsm_param.md
VEND_FSM_PARAM -- requirements
Module: vend_fsm_param

Interface
REQ-001 SHALL have parameter CW, default 8, meaning credit register width in bits.
REQ-002 SHALL have parameter PRICE, default 15, meaning item price in currency units.
REQ-003 SHALL have parameter UNIT, default 5, meaning value of one returned change coin.
REQ-004 SHALL have parameters V0, V1, V2, defaults 5, 10, 20, meaning values of coin_type 0, 1, 2.
REQ-005 SHALL have port clock, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port coin_valid, input, 1, a coin is presented this cycle.
REQ-008 SHALL have port coin_type, input, 2, denomination select; 3 is invalid.
REQ-009 SHALL have port cancel, input, 1, customer abort request.
REQ-010 SHALL have port purchase, output, 1, item release pulse.
REQ-011 SHALL have port change_pulse, output, 1, release one UNIT coin this cycle.
REQ-012 SHALL have port coin_reject, output, 1, registered pulse: previous cycle's coin returned unaccepted.
REQ-013 SHALL have port busy, output, 1, high in VEND or REFUND.
REQ-014 SHALL have port credit, output, CW, current held credit.
REQ-015 SHALL have port state, output, 2, IDLE=00, COLLECT=01, VEND=10, REFUND=11.

Function
REQ-016 SHALL require PRICE, V0..V2 to be nonzero multiples of UNIT and PRICE+V2-UNIT < 2^CW; elaboration check only.
REQ-017 SHALL, in IDLE or COLLECT, accept a coin with coin_valid=1, coin_type<3, cancel=0: credit <= credit+Vn at next edge.
REQ-018 SHALL go IDLE->COLLECT on an accepted coin whose new credit < PRICE; either state goes to VEND when new credit >= PRICE.
REQ-019 SHALL, in COLLECT with cancel=1, go to REFUND at next edge; cancel wins over a same-cycle coin, which is rejected.
REQ-020 SHALL ignore cancel in IDLE, VEND, REFUND.
REQ-021 SHALL reject any coin with coin_type=3, any coin arriving in VEND or REFUND, and any coin coincident with an accepted cancel; credit unchanged, coin_reject=1 in the following cycle only.
REQ-022 SHALL assert purchase combinationally for exactly the one cycle state==VEND.
REQ-023 SHALL, on leaving VEND, set credit <= credit-PRICE; go REFUND if result > 0, else IDLE.
REQ-024 SHALL assert change_pulse every cycle state==REFUND and set credit <= credit-UNIT each such cycle.
REQ-025 SHALL leave REFUND for IDLE on the edge where credit == UNIT (credit becomes 0); REFUND never entered with credit 0.
REQ-026 SHALL hold credit 0 whenever state==IDLE.
REQ-027 SHALL have busy = (state==VEND || state==REFUND), combinational.
REQ-028 SHALL give coin-to-purchase latency of 1 cycle: completing coin at edge t, purchase high in cycle t..t+1.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, force state=IDLE, credit=0, coin_reject=0, from any state including mid-REFUND; undelivered change is forfeited.
REQ-030 SHALL keep purchase, change_pulse, busy at 0 while state==IDLE after reset.

Verification
REQ-031 SHALL cover: coin 10 then 5 -> credit 10, then VEND, purchase 1 cycle, 0 change_pulse, IDLE credit 0.
REQ-032 SHALL cover: coin 10 then 10 -> credit 20, VEND purchase 1 cycle, REFUND 1 change_pulse, IDLE.
REQ-033 SHALL cover: coin 10 then cancel -> REFUND, 2 change_pulse, purchase never asserted, IDLE.
REQ-034 SHALL cover: single coin 20 from IDLE -> VEND next cycle, then 1 change_pulse.
REQ-035 SHALL cover: coin_type 3 in IDLE, coin 5 during REFUND, coin+cancel same cycle -> coin_reject 1 cycle each, credit unaffected.
REQ-036 SHALL cover: reset asserted during REFUND with credit 10 -> next edge state 00, credit 0, change_pulse 0.
